// File: rtl/if_fetch_unit.sv
// Purpose : instruction-fetch stage that owns the PC and feeds the IF/ID register.
// Latency : zero-wait memory gives one instruction per cycle. IF outputs follow the ack combinationally.
// Backpress: stall parks an acked word in a hold buffer. A redirect drains any outstanding stale request.
//
// Ports:
//   i_clk, i_rst              clock; synchronous active-high reset
//   i_stall, i_redirect       IF/ID stall and flush controls (redirect wins)
//   i_redirect_pc             branch/jump target (low two bits ignored)
//   o_imem_req, o_imem_addr   instruction memory request (held stable until ack)
//   i_imem_ack, i_imem_rdata  memory completion and returned word
//   o_IF_pc_4, o_IF_inst,     presented {pc+4, instruction} with a valid flag;
//   o_IF_valid                NOP and 0 are presented when there is no valid word
module if_fetch_unit #(
  parameter int               PC_W     = 9,
  parameter logic [PC_W-1:0]  RESET_PC = '0,
  parameter logic [31:0]      NOP      = 32'h0000_0020
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_stall,
  input  logic            i_redirect,
  input  logic [PC_W-1:0] i_redirect_pc,
  output logic            o_imem_req,
  output logic [PC_W-1:0] o_imem_addr,
  input  logic            i_imem_ack,
  input  logic [31:0]     i_imem_rdata,
  output logic [PC_W-1:0] o_IF_pc_4,
  output logic [31:0]     o_IF_inst,
  output logic            o_IF_valid
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_HOLD  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t          r_state;
  logic [PC_W-1:0] r_pc;
  logic [PC_W-1:0] r_drain_addr;
  logic [31:0]     r_buf;

  logic [PC_W-1:0] w_pc_4;
  logic [PC_W-1:0] w_redir_pc;

  // PC arithmetic wraps naturally at the PC_W boundary.
  assign w_pc_4     = r_pc + PC_W'(4);
  // Redirect targets are forced word aligned.
  assign w_redir_pc = i_redirect_pc & ~PC_W'(3);

  // Output decode. The fetch outputs depend combinationally on the ack so a
  // zero-wait memory can deliver one word per cycle. Any redirect, and reset,
  // turns the presented slot into a bubble.
  always_comb begin
    o_imem_req  = 1'b0;
    o_imem_addr = r_pc;
    o_IF_valid  = 1'b0;
    o_IF_inst   = NOP;
    o_IF_pc_4   = '0;
    if (i_rst) begin
      o_imem_addr = RESET_PC;
    end else begin
      case (r_state)
        S_FETCH: begin
          o_imem_req = 1'b1;
          if (i_imem_ack && !i_redirect) begin
            o_IF_valid = 1'b1;
            o_IF_inst  = i_imem_rdata;
            o_IF_pc_4  = w_pc_4;
          end
        end
        S_HOLD: begin
          if (!i_redirect) begin
            o_IF_valid = 1'b1;
            o_IF_inst  = r_buf;
            o_IF_pc_4  = w_pc_4;
          end
        end
        S_DRAIN: begin
          // Keep the stale request on the bus until memory completes it.
          o_imem_req  = 1'b1;
          o_imem_addr = r_drain_addr;
        end
        default: begin
          o_imem_req = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= S_FETCH;
      r_pc         <= RESET_PC;
      r_buf        <= NOP;
      r_drain_addr <= RESET_PC;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (i_redirect) begin
            r_pc <= w_redir_pc;
            if (!i_imem_ack) begin
              // The request is already on the bus and must stay stable, so
              // remember its address and throw its data away when it lands.
              r_drain_addr <= r_pc;
              r_state      <= S_DRAIN;
            end
          end else if (i_imem_ack) begin
            if (i_stall) begin
              r_buf   <= i_imem_rdata;
              r_state <= S_HOLD;
            end else begin
              r_pc <= w_pc_4;
            end
          end
          // A stall without an ack changes nothing: the request stays pending.
        end
        S_HOLD: begin
          if (i_redirect) begin
            r_pc    <= w_redir_pc;
            r_state <= S_FETCH;
          end else if (!i_stall) begin
            r_pc    <= w_pc_4;
            r_state <= S_FETCH;
          end
        end
        S_DRAIN: begin
          // A later redirect only retargets the PC; the drained address is fixed.
          if (i_redirect) begin
            r_pc <= w_redir_pc;
          end
          if (i_imem_ack) begin
            r_state <= S_FETCH;
          end
        end
        default: begin
          r_state <= S_FETCH;
        end
      endcase
    end
  end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline; producer side of the IF/ID interface.
- Owns the 9-bit PC and issues requests to instruction memory over a req/ack handshake.
- Presents {IF_pc_4, IF_inst} to the IF/ID register, obeying the same stall and flush (redirect) controls that register receives.
- Buffers a returned word during stall; discards in-flight fetches made stale by a branch/jump redirect.

Parameters:
PC_W, 9, PC / address width in bits (byte address, word aligned)
RESET_PC, 9'h000, PC loaded on reset
NOP, 32'h0000_0020, bubble instruction (add $0,$0,$0) driven when no valid word

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
stall  input  1  hold current fetch output; same signal as IF/ID stall
redirect  input  1  branch/jump taken; same signal as IF/ID flush
redirect_pc  input  PC_W  redirect target; bits [1:0] ignored (forced 0)
imem_req  output  1  memory request valid
imem_addr  output  PC_W  memory word byte address
imem_ack  input  1  memory returns imem_rdata this cycle (only meaningful while imem_req=1)
imem_rdata  input  32  instruction word, valid when imem_ack=1
IF_pc_4  output  PC_W  PC+4 of presented instruction, 0 when IF_valid=0
IF_inst  output  32  presented instruction, NOP when IF_valid=0
IF_valid  output  1  IF_inst holds a real fetched word

Behaviour:
- PC arithmetic:
  - pc+4 is modulo 2^PC_W, so 0x1FC+4 = 0x000.
  - redirect_pc is loaded with [1:0]=0.
- State register: FETCH, HOLD, DRAIN. Registers: pc, state, buf[31:0], drain_addr.
- Reset (rst=1 at an edge):
  - Loads pc=RESET_PC, state=FETCH, buf=NOP.
  - While rst=1: imem_req=0, imem_addr=RESET_PC, IF_valid=0, IF_inst=NOP, IF_pc_4=0.
  - Reset mid-transaction abandons the outstanding request; imem must be reset by the same rst.
- Handshake:
  - Once imem_req=1, imem_req and imem_addr hold stable until the imem_ack cycle.
  - Ack completes the transfer in that cycle. Zero-wait (ack same cycle as first req) is legal.
- FETCH: imem_req=1, imem_addr=pc.
  - ack=1: outputs are combinational: IF_inst=imem_rdata, IF_pc_4=pc+4, IF_valid=1.
    - stall=0: pc<=pc+4, stay FETCH, new request next cycle.
    - stall=1: buf<=imem_rdata, go HOLD.
  - ack=0: IF_valid=0, IF_inst=NOP, IF_pc_4=0 (bubble into IF/ID).
- HOLD: imem_req=0, imem_addr=pc, IF_inst=buf, IF_pc_4=pc+4, IF_valid=1.
  - stall=0: pc<=pc+4, go FETCH.
  - stall=1: stay HOLD; outputs bit-stable.
- DRAIN: imem_req=1, imem_addr=drain_addr, IF_valid=0, outputs NOP/0.
  - ack=1: data discarded, go FETCH.
- Redirect (priority over stall, all states):
  - Outputs that cycle are IF_valid=0, NOP, 0; IF/ID flushes anyway.
  - pc<=redirect_pc aligned.
  - FETCH with ack=0: drain_addr<=pc, go DRAIN (request stays stable).
  - FETCH with ack=1: go FETCH; data is dropped.
  - HOLD: go FETCH; buf is dropped.
  - DRAIN: pc updates again, stay DRAIN, drain_addr unchanged; ack that same cycle goes to FETCH.
- Latency:
  - Zero-wait memory with no stall: one instruction per cycle.
  - First request is in the cycle after rst deasserts.
- Stall in a non-ack FETCH cycle has no effect; the request stays pending.

Test Plan:
1. Reset 2 cycles; memory acks same cycle with rdata=0x2000_0000|addr -> IF_inst 0x2000_0000, 0x2000_0004, 0x2000_0008 with IF_pc_4 0x004, 0x008, 0x00C on consecutive cycles; IF_valid=1.
2. Stall=1 for 3 cycles on the ack cycle of addr 0x008 -> HOLD: imem_req=0, IF_inst=0x2000_0008, IF_pc_4=0x00C stable 3 cycles; next request is addr 0x00C after stall drops.
3. Memory acks 2 cycles after req -> imem_addr/imem_req stable, IF_valid=0 and IF_inst=0x0000_0020 during wait; valid word on ack cycle.
4. Redirect to 0x043 while addr 0x010 is outstanding, ack 2 cycles later -> DRAIN holds addr 0x010, word discarded (IF_valid stays 0), next request addr 0x040, presented IF_pc_4=0x044.
5. Redirect=1 and stall=1 same cycle in HOLD -> redirect wins: buf dropped, FETCH at redirect target the next cycle.
6. Redirect to 0x1FC, zero-wait memory -> IF_pc_4=0x000, following request addr 0x000 (wrap). Separately, rst asserted mid-DRAIN -> imem_req=0 and state FETCH at RESET_PC.
